// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared FSM state type and digit-adjust constants for bin2bcd_seq
package bin2bcd_seq_pkg;
    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_ADD = 4'd3;
endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// bcd_digit_adj: add 3 to a BCD digit of 5 or more before the double-dabble shift
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);
    assign adj = (digit >= ADJ_THRESH) ? digit + ADJ_ADD : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle double-dabble converter with start/busy/done handshake
// BIN2BCD_LEADING_BLANK_EN enables the registered leading-zero BLANK mask
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   START,
    input  logic [BIN_W-1:0]       BIN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [4*DIGITS-1:0]    BCD,
    output logic                   OVF,
    output logic [DIGITS-1:0]      BLANK
);
    localparam int SW = DIGIT_W * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    state_t           state;
    logic [BIN_W-1:0] shreg;
    logic [SW-1:0]    scr;
    logic [SW-1:0]    adj;
    logic [CW-1:0]    cnt;
    logic             sticky;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit(scr[g*DIGIT_W +: DIGIT_W]),
            .adj  (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state  <= IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            BCD    <= '0;
            OVF    <= 1'b0;
            shreg  <= '0;
            scr    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    shreg  <= BIN;
                    scr    <= '0;
                    cnt    <= CW'(BIN_W);
                    sticky <= 1'b0;
                    BUSY   <= 1'b1;
                    state  <= CONV;
                end
                CONV: begin
                    // the adjusted scratch MSB is the bit lost off the top of the shift
                    {scr, shreg} <= {adj, shreg} << 1;
                    sticky       <= sticky | adj[SW-1];
                    cnt          <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    BCD   <= scr;
                    OVF   <= sticky;
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIN2BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              z;

    always_comb begin
        blank_nx = '0;
        z = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z = z & (scr[k*DIGIT_W +: DIGIT_W] == '0);
            blank_nx[k] = z;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN)
            BLANK <= '0;
        else if (state == FIN)
            BLANK <= blank_nx;
    end
`else
    assign BLANK = '0;
`endif
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per cycle. Sits directly upstream of the 7-segment decoder stage. Each BCD nibble of its output drives one decoder instance (HEX0..HEX3 on the board). Uses a start/busy/done handshake so the datapath or counter can post a binary value and the display updates atomically.

Parameters:
BIN_W, 14, width of binary input (14 covers 0..9999).
DIGITS, 4, number of BCD digits produced.

Ports:
CLK  in  1  system clock, all state on rising edge.
RSTN  in  1  synchronous reset, active-low.
START  in  1  request conversion of BIN; sampled only in IDLE.
BIN  in  BIN_W  unsigned binary value; latched on accepted START.
BUSY  out  1  high while converting (state CONV).
DONE  out  1  one-cycle pulse when BCD/OVF are updated.
BCD  out  4*DIGITS  result; digit k at bits [4k+3:4k], digit 0 = least significant.
OVF  out  1  result did not fit; BCD holds value mod 10^DIGITS.
BLANK  out  DIGITS  leading-zero mask (see Optional Feature).

Behaviour:
- Reset (RSTN=0 at a clock edge): state=IDLE; BUSY=0, DONE=0, BCD=0, OVF=0, BLANK=0; shift and scratch registers cleared. Reset overrides everything, including mid-conversion; the partial result is discarded.
- States: IDLE, CONV, FIN.
  - IDLE -> CONV when START=1. BIN goes into the shift register, the BCD scratch register is cleared, the iteration counter is set to BIN_W, and the sticky overflow bit is cleared.
  - CONV, each cycle:
    - Every scratch digit >= 5 gets +3 (4-bit, no carry out).
    - Then {scratch, shift} shifts left by 1.
    - The bit leaving the scratch MSB ORs into sticky overflow.
    - The counter decrements; at 1 -> FIN.
  - FIN, one cycle: BCD <= scratch, OVF <= sticky, DONE=1; -> IDLE.
- Latency: START accepted at edge 0; BUSY is high for exactly BIN_W cycles; DONE is high on cycle BIN_W+1. With defaults, DONE occurs 15 cycles after the START edge.
- Next conversion: START may be accepted in the cycle after FIN (back-to-back throughput = BIN_W+2 cycles).
- START while BUSY or in FIN: ignored, not queued.
- BIN changing after acceptance: no effect.
- BCD and OVF hold their last values between conversions; they never show partial results.
- Arithmetic: digit adjust operates on each 4-bit nibble independently. The scratch register is 4*DIGITS bits. Truncation yields the correct low DIGITS decimal digits.
- Edge cases:
  - BIN=0 gives BCD=0, OVF=0.
  - With BIN_W <= 3, no adjust ever fires; result still correct.

Optional Feature:
Macro BIN2BCD_LEADING_BLANK_EN.
- Defined: BLANK is registered in FIN alongside BCD. BLANK[k]=1 iff digits DIGITS-1..k are all zero, for k >= 1; BLANK[0] is always 0, so a zero value still shows "0". Downstream forces the corresponding segments off.
- Undefined: BLANK is tied to 0 and no extra logic is built.
- The port exists in both builds.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/CONV/FIN);
  - constant DIGIT_W=4;
  - constant ADJ_THRESH=5 and ADJ_ADD=3.
- One natural sub-module: bcd_digit_adj, combinational. Input: 4-bit digit. Output: digit+3 if >= 5, else digit. Instantiated DIGITS times by generate.

Test Plan:
- Reset, then BIN=0 with START pulse: DONE exactly 15 cycles later; BCD=0x0000, OVF=0, BUSY high for 14 cycles.
- BIN=1234, then BIN=9999, back-to-back (START in the cycle after each FIN): BCD=0x1234 then 0x9999, OVF=0 both times.
- BIN=10000: BCD=0x0000, OVF=1. BIN=16383: BCD=0x6383, OVF=1.
- BIN=42, with START held high for 20 cycles and BIN changed to 7 mid-conversion: exactly one DONE, BCD=0x0042; a second conversion begins only on a START seen in IDLE.
- BIN=5678 started; RSTN=0 for 1 cycle at BUSY cycle 6: no DONE, BCD=0x0000, BUSY=0, state IDLE; a new START with BIN=5678 gives 0x5678.
- With BIN2BCD_LEADING_BLANK_EN:
  - BIN=7: BLANK=4'b1110.
  - BIN=0: BLANK=4'b1110.
  - BIN=1005: BLANK=4'b0000.
  - Without the macro, BLANK=0 always.
